// File: rtl/fbdsp_pkg.sv
// Shared types and constants for the FBDSP iterative fractured multiplier.
package fbdsp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_FULL   = 1'b0;
    localparam logic MODE_PACKED = 1'b1;

    localparam int K_FULL   = 4;
    localparam int K_PACKED = 2;

endpackage

// File: rtl/fbdsp_half_mult.sv
// Combinational signed AW x BW multiplier shared by every partial-product step.
module fbdsp_half_mult #(
    parameter int AW = 5,
    parameter int BW = 5
) (
    input  logic signed [AW-1:0]    i_a,
    input  logic signed [BW-1:0]    i_b,
    output logic signed [AW+BW-1:0] o_p
);

    assign o_p = i_a * i_b;

endmodule

// File: rtl/fbdsp_iter_mult.sv
// Iterative fractured N x M multiplier: 4-step full product or 2-step packed dual-lane.
// Optional running accumulation enabled by defining FBDSP_ACC_EN.
module fbdsp_iter_mult
    import fbdsp_pkg::*;
#(
    parameter int N = 8,
    parameter int M = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           mode,
    input  logic           sign_a,
    input  logic           sign_b,
    input  logic [N-1:0]   aa,
    input  logic [M-1:0]   bb,
`ifdef FBDSP_ACC_EN
    input  logic           acc_en,
    input  logic           acc_clr,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N+M-1:0] out,
    output logic           busy
);

    localparam int NH = N / 2;
    localparam int MH = M / 2;
    localparam int HA = NH + 1;
    localparam int HB = MH + 1;
    localparam int PW = HA + HB;
    localparam int W  = N + M;
    localparam int LW = NH + MH;

    state_t             r_state, w_state_next;
    logic [1:0]         r_cnt;
    logic               r_mode, r_sign_a, r_sign_b;
    logic [N-1:0]       r_aa;
    logic [M-1:0]       r_bb;
    logic [W-1:0]       r_acc, r_out;
    logic               r_out_valid;

    logic               w_accept, w_last, w_in_ready, w_packed, w_b_hi;
    logic signed [HA-1:0] w_a_sel;
    logic signed [HB-1:0] w_b_sel;
    logic signed [PW-1:0] w_pp;
    logic [W-1:0]       w_pp_ext, w_term, w_acc_next, w_base;

    assign w_packed = (r_mode == MODE_PACKED);
    assign w_last   = w_packed ? (r_cnt == 2'(K_PACKED - 1)) : (r_cnt == 2'(K_FULL - 1));
    assign w_accept = in_valid && w_in_ready;

    // Low halves carry a sign bit only as independent packed lanes; high halves always honour sign.
    assign w_b_hi  = w_packed ? r_cnt[0] : r_cnt[1];
    assign w_a_sel = r_cnt[0] ? {r_sign_a & r_aa[N-1], r_aa[N-1:NH]}
                              : {w_packed & r_sign_a & r_aa[NH-1], r_aa[NH-1:0]};
    assign w_b_sel = w_b_hi   ? {r_sign_b & r_bb[M-1], r_bb[M-1:MH]}
                              : {w_packed & r_sign_b & r_bb[MH-1], r_bb[MH-1:0]};

    fbdsp_half_mult #(.AW(HA), .BW(HB)) u_half_mult (
        .i_a (w_a_sel),
        .i_b (w_b_sel),
        .o_p (w_pp)
    );

    assign w_pp_ext = {{(W - PW){w_pp[PW-1]}}, w_pp};

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        w_term     = w_pp_ext;
        w_acc_next = r_acc;
        case (r_cnt)
            2'd0:    w_term = w_pp_ext;
            2'd1:    w_term = w_pp_ext << NH;
            2'd2:    w_term = w_pp_ext << MH;
            default: w_term = w_pp_ext << (NH + MH);
        endcase
        if (!w_packed) begin
            w_acc_next = r_acc + w_term;
        end else if (!r_cnt[0]) begin
            w_acc_next[LW-1:0] = r_acc[LW-1:0] + w_pp[LW-1:0];
        end else begin
            w_acc_next[W-1:LW] = r_acc[W-1:LW] + w_pp[LW-1:0];
        end
    end

`ifdef FBDSP_ACC_EN
    assign w_base = (acc_en && !acc_clr) ? r_out : '0;
`else
    assign w_base = '0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) w_state_next = MUL;
            end
            MUL: begin
                busy = 1'b1;
                if (w_last) w_state_next = DONE;
            end
            DONE: begin
                w_in_ready = out_ready;
                if (out_ready) w_state_next = in_valid ? MUL : IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_out_valid <= (w_state_next == DONE);
            if (w_accept)            r_cnt <= '0;
            else if (r_state == MUL) r_cnt <= r_cnt + 2'd1;
            if (r_state == MUL && w_last) r_out <= w_acc_next;
        end
    end

    // NOTE: operand and accumulator flops carry no reset; they are always reloaded on acceptance.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_aa     <= aa;
            r_bb     <= bb;
            r_mode   <= mode;
            r_sign_a <= sign_a;
            r_sign_b <= sign_b;
            r_acc    <= w_base;
        end else if (r_state == MUL) begin
            r_acc    <= w_acc_next;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out       = r_out;

endmodule
